// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter encodings and PC slicing helpers.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam logic [1:0] CTR_RESET = WNT;
    localparam logic [1:0] CTR_ALLOC = WT;

    // Helpers work on a 64-bit container so any XLEN up to 64 can share them.
    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned ib);
        return (pc >> 2) & ((64'd1 << ib) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned ib);
        return pc >> (ib + 2);
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating up/down branch counter.
module sat_counter2 (
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i && ctr_i != 2'b11)
            ctr_o = ctr_i + 2'd1;
        else if (!taken_i && ctr_i != 2'b00)
            ctr_o = ctr_i - 2'd1;
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side predictor: 2-bit BHT plus direct-mapped BTB, trained from EX.
// Optional GSHARE_EN macro hashes the counter index with a global history register.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [XLEN-1:0]       if_pc,
    output logic                  pred_taken,
    output logic [XLEN-1:0]       pred_target,
    input  logic                  ex_valid,
    input  logic [XLEN-1:0]       ex_pc,
    input  logic                  ex_taken,
    input  logic [XLEN-1:0]       ex_target,
    input  logic                  ex_pred_taken,
    input  logic [XLEN-1:0]       ex_pred_target,
`ifdef GSHARE_EN
    output logic [INDEX_BITS-1:0] pred_ghr,
    input  logic [INDEX_BITS-1:0] ex_ghr,
`endif
    output logic                  mispredict,
    output logic [XLEN-1:0]       redirect_pc,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
);

    localparam int DEPTH = 1 << INDEX_BITS;
    localparam int TAG_W = XLEN - INDEX_BITS - 2;

    logic            valid_q  [DEPTH];
    logic [TAG_W-1:0] tag_q   [DEPTH];
    logic [XLEN-1:0] target_q [DEPTH];
    logic [1:0]      ctr_q    [DEPTH];

    logic [31:0] stat_b_q, stat_b_d;
    logic [31:0] stat_m_q, stat_m_d;

    logic [INDEX_BITS-1:0] if_idx, ex_idx, if_cidx, ex_cidx;
    logic [TAG_W-1:0]      if_tag, ex_tag;
    logic                  if_hit, ex_hit;
    logic [1:0]            ctr_upd;

    assign if_idx = INDEX_BITS'(pc_index(64'(if_pc), INDEX_BITS));
    assign ex_idx = INDEX_BITS'(pc_index(64'(ex_pc), INDEX_BITS));
    assign if_tag = TAG_W'(pc_tag(64'(if_pc), INDEX_BITS));
    assign ex_tag = TAG_W'(pc_tag(64'(ex_pc), INDEX_BITS));

`ifdef GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_q;
    // Only the counters are history-hashed; BTB tag/target stay PC-indexed.
    assign if_cidx  = if_idx ^ ghr_q;
    assign ex_cidx  = ex_idx ^ ex_ghr;
    assign pred_ghr = ghr_q;
`else
    assign if_cidx = if_idx;
    assign ex_cidx = ex_idx;
`endif

    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign pred_taken  = if_hit && ctr_q[if_cidx][1];
    assign pred_target = if_hit ? target_q[if_idx] : '0;

    assign mispredict = ex_valid &&
                        ((ex_taken != ex_pred_taken) ||
                         (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
    assign redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);

    sat_counter2 u_ctr (
        .ctr_i   (ctr_q[ex_cidx]),
        .taken_i (ex_taken),
        .ctr_o   (ctr_upd)
    );

    always_comb begin
        stat_b_d = stat_b_q;
        stat_m_d = stat_m_q;
        if (ex_valid) begin
            if (stat_b_q != 32'hFFFF_FFFF)
                stat_b_d = stat_b_q + 32'd1;
            if (mispredict && stat_m_q != 32'hFFFF_FFFF)
                stat_m_d = stat_m_q + 32'd1;
        end
    end

    // Table writes land at the edge, so a same-cycle IF read sees the old entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
            stat_b_q <= '0;
            stat_m_q <= '0;
        end else begin
            if (ex_valid) begin
                if (ex_hit) begin
                    ctr_q[ex_cidx] <= ctr_upd;
                    if (ex_taken)
                        target_q[ex_idx] <= ex_target;
                end else if (ex_taken) begin
                    valid_q[ex_idx]  <= 1'b1;
                    tag_q[ex_idx]    <= ex_tag;
                    target_q[ex_idx] <= ex_target;
                    ctr_q[ex_cidx]   <= CTR_ALLOC;
                end
            end
            stat_b_q <= stat_b_d;
            stat_m_q <= stat_m_d;
        end
    end

`ifdef GSHARE_EN
    // A mispredict rebuilds history from the branch's own snapshot.
    always_ff @(posedge clk) begin
        if (reset)
            ghr_q <= '0;
        else if (ex_valid) begin
            if (mispredict)
                ghr_q <= {ex_ghr[INDEX_BITS-2:0], ex_taken};
            else
                ghr_q <= {ghr_q[INDEX_BITS-2:0], ex_taken};
        end
    end
`endif

    assign stat_branches    = stat_b_q;
    assign stat_mispredicts = stat_m_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (INDEX_BITS=6, XLEN=32).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`ifdef GSHARE_EN
    logic [5:0]  pred_ghr;
    logic [5:0]  ex_ghr;
`endif

    int n_total = 0;
    int n_pass  = 0;

    branch_predictor #(.INDEX_BITS(6), .XLEN(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
`ifdef GSHARE_EN
        .pred_ghr         (pred_ghr),
        .ex_ghr           (ex_ghr),
`endif
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] if_pc;
        logic        ev;
        logic [31:0] ex_pc;
        logic        et;
        logic [31:0] etgt;
        logic        ept;
        logic [31:0] eptgt;
        logic        x_pt;
        logic [31:0] x_ptgt;
        logic        x_mp;
        logic [31:0] x_rd;
        logic [31:0] x_sb;
        logic [31:0] x_sm;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s (step %0d): got %h, expected %h", name, id, act, exp);
        else
            n_pass++;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_pc = 0; ex_taken = 0; ex_target = 0;
        ex_pred_taken = 0; ex_pred_target = 0;
`ifdef GSHARE_EN
        ex_ghr = 0;
`endif
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    initial begin
        reset = 1; if_pc = 0;
        idle_inputs();
        do_reset();
        if_pc = 32'h100;
        @(negedge clk);
        chk("reset_pred_taken",  -1, 32'(pred_taken), 32'd0);
        chk("reset_pred_target", -1, pred_target, 32'd0);
        chk("reset_stat_b",      -1, stat_branches, 32'd0);
        chk("reset_stat_m",      -1, stat_mispredicts, 32'd0);

`ifndef GSHARE_EN
        //              if_pc  ev ex_pc  et etgt   ept eptgt  pt ptgt   mp rd     sb  sm
        vecs.push_back('{32'h100,0,32'h100,1,32'h140,0,32'h0,  0,32'h0,  0,32'h0,  0, 0});
        vecs.push_back('{32'h104,1,32'h100,1,32'h140,0,32'h0,  0,32'h0,  1,32'h140,0, 0});
        vecs.push_back('{32'h100,0,32'h0,  0,32'h0,  0,32'h0,  1,32'h140,0,32'h0,  1, 1});
        vecs.push_back('{32'h100,1,32'h100,0,32'h0,  1,32'h140,1,32'h140,1,32'h104,1, 1});
        vecs.push_back('{32'h100,1,32'h100,0,32'h0,  0,32'h0,  0,32'h140,0,32'h0,  2, 2});
        vecs.push_back('{32'h100,0,32'h0,  0,32'h0,  0,32'h0,  0,32'h140,0,32'h0,  3, 2});
        vecs.push_back('{32'h100,1,32'h100,1,32'h140,0,32'h0,  0,32'h140,1,32'h140,3, 2});
        vecs.push_back('{32'h100,1,32'h100,1,32'h140,0,32'h0,  0,32'h140,1,32'h140,4, 3});
        vecs.push_back('{32'h100,0,32'h0,  0,32'h0,  0,32'h0,  1,32'h140,0,32'h0,  5, 4});
        vecs.push_back('{32'h100,1,32'h100,1,32'h140,1,32'h140,1,32'h140,0,32'h0,  5, 4});
        vecs.push_back('{32'h100,1,32'h100,1,32'h140,1,32'h140,1,32'h140,0,32'h0,  6, 4});
        vecs.push_back('{32'h100,1,32'h100,1,32'h140,1,32'h140,1,32'h140,0,32'h0,  7, 4});
        vecs.push_back('{32'h100,1,32'h100,1,32'h140,1,32'h140,1,32'h140,0,32'h0,  8, 4});
        vecs.push_back('{32'h100,0,32'h0,  0,32'h0,  0,32'h0,  1,32'h140,0,32'h0,  9, 4});
        vecs.push_back('{32'h100,1,32'h100,0,32'h0,  1,32'h140,1,32'h140,1,32'h104,9, 4});
        vecs.push_back('{32'h100,0,32'h0,  0,32'h0,  0,32'h0,  1,32'h140,0,32'h0, 10, 5});
        vecs.push_back('{32'h200,0,32'h0,  0,32'h0,  0,32'h0,  0,32'h0,  0,32'h0, 10, 5});
        vecs.push_back('{32'h200,1,32'h200,1,32'h240,0,32'h0,  0,32'h0,  1,32'h240,10,5});
        vecs.push_back('{32'h200,0,32'h0,  0,32'h0,  0,32'h0,  1,32'h240,0,32'h0, 11, 6});
        vecs.push_back('{32'h100,0,32'h0,  0,32'h0,  0,32'h0,  0,32'h0,  0,32'h0, 11, 6});
        vecs.push_back('{32'h200,1,32'h200,1,32'h280,1,32'h240,1,32'h240,1,32'h280,11,6});
        vecs.push_back('{32'h200,0,32'h0,  0,32'h0,  0,32'h0,  1,32'h280,0,32'h0, 12, 7});
        vecs.push_back('{32'h200,1,32'h300,0,32'h0,  0,32'h0,  1,32'h280,0,32'h0, 12, 7});
        vecs.push_back('{32'h200,0,32'h0,  0,32'h0,  0,32'h0,  1,32'h280,0,32'h0, 13, 7});
        vecs.push_back('{32'h200,1,32'hFFFF_FFFC,0,32'h0,1,32'h10,1,32'h280,1,32'h0,13,7});
        vecs.push_back('{32'hFFFF_FFFC,0,32'h0,0,32'h0,0,32'h0,0,32'h0,  0,32'h0, 14, 8});

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            if_pc          = vecs[i].if_pc;
            ex_valid       = vecs[i].ev;
            ex_pc          = vecs[i].ex_pc;
            ex_taken       = vecs[i].et;
            ex_target      = vecs[i].etgt;
            ex_pred_taken  = vecs[i].ept;
            ex_pred_target = vecs[i].eptgt;
            @(negedge clk);
            chk("pred_taken",  i, 32'(pred_taken), 32'(vecs[i].x_pt));
            chk("pred_target", i, pred_target, vecs[i].x_ptgt);
            chk("mispredict",  i, 32'(mispredict), 32'(vecs[i].x_mp));
            if (vecs[i].x_mp)
                chk("redirect_pc", i, redirect_pc, vecs[i].x_rd);
            chk("stat_branches",    i, stat_branches, vecs[i].x_sb);
            chk("stat_mispredicts", i, stat_mispredicts, vecs[i].x_sm);
        end

        // Reset held while EX resolves a taken branch: reset must win.
        @(posedge clk); #1;
        reset = 1; ex_valid = 1; ex_pc = 32'h400; ex_taken = 1;
        ex_target = 32'h440; ex_pred_taken = 0;
        @(posedge clk); #1;
        reset = 0;
        idle_inputs();
        if_pc = 32'h400;
        @(negedge clk);
        chk("rst_dom_pred_taken",  100, 32'(pred_taken), 32'd0);
        chk("rst_dom_pred_target", 100, pred_target, 32'd0);
        chk("rst_dom_stat_b",      100, stat_branches, 32'd0);
        chk("rst_dom_stat_m",      100, stat_mispredicts, 32'd0);
        if_pc = 32'h200;
        #1;
        chk("rst_clears_entry", 101, 32'(pred_taken), 32'd0);
`else
        begin
            int late_mp;
            late_mp = 0;
            for (int i = 0; i < 24; i++) begin
                @(posedge clk); #1;
                if_pc     = 32'h100;
                ex_valid  = 1;
                ex_pc     = 32'h100;
                ex_taken  = (i % 2 == 0);
                ex_target = 32'h140;
                #1;
                ex_pred_taken  = pred_taken;
                ex_pred_target = pred_target;
                ex_ghr         = pred_ghr;
                #1;
                if (i >= 12 && mispredict) late_mp++;
            end
            chk("gshare_converged", 200, 32'(late_mp), 32'd0);
            @(posedge clk); #1;
            ex_valid = 1; ex_pc = 32'h100; ex_taken = 1; ex_target = 32'h140;
            ex_pred_taken = 0; ex_pred_target = 0; ex_ghr = 6'b000011;
            @(negedge clk);
            chk("gshare_forced_mp", 201, 32'(mispredict), 32'd1);
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            chk("gshare_ghr_repair", 202, 32'(pred_ghr), 32'h07);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule
